// File: rtl/sprite_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : sprite_frame_loader
// Description : Copies one 256-pixel animation frame from sprite ROM into
//               sprite RAM during vertical blank, when a different frame is
//               requested or the resident copy has been invalidated.
// Ports       : Clk, Reset_n (async, active-low)
//               vblank_start, load_en, frame_sel, force_reload - requests
//               rom_addr / rom_data                          - ROM read port
//               ram_we / ram_waddr / ram_wdata               - RAM write port
//               busy, done, cur_frame, cur_valid, overrun    - status
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_frame_loader #(
  parameter int FRAMES = 8,
  parameter int DATA_W = 6,
  localparam int FW    = $clog2(FRAMES)
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              vblank_start,
  input  logic              load_en,
  input  logic [FW-1:0]     frame_sel,
  input  logic              force_reload,
  output logic [FW+7:0]     rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              ram_we,
  output logic [7:0]        ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              busy,
  output logic              done,
  output logic [FW-1:0]     cur_frame,
  output logic              cur_valid,
  output logic              overrun
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_COPY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [8:0]      r_i;          // bit 8 marks "all 256 reads issued"
  logic [FW-1:0]   r_sel;
  logic            r_we;
  logic [7:0]      r_waddr;
  logic            r_pend;       // force_reload seen while copying
  logic [FW-1:0]   r_cur_frame;
  logic            r_cur_valid;
  logic            r_overrun;
  logic            w_start;
  logic            w_copy_last;
  logic            w_reading;

  assign w_start     = (r_state == S_IDLE) && vblank_start && load_en &&
                       (!r_cur_valid || (frame_sel != r_cur_frame) || force_reload);
  assign w_reading   = (r_state == S_COPY) && !r_i[8];
  // The final write (index 255) happens in the cycle after the last read.
  assign w_copy_last = (r_state == S_COPY) && r_i[8];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_COPY;
      S_COPY:  if (w_copy_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Read counter, write stage and request bookkeeping.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_i       <= '0;
      r_sel     <= '0;
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_pend    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_reading) begin
        r_i <= r_i + 9'd1;
      end else if (r_state != S_COPY) begin
        r_i <= '0;
      end
      if (w_start) begin
        r_sel <= frame_sel;
      end
      // ROM data for address i arrives one cycle later, so the write lags by one.
      r_we      <= w_reading;
      r_waddr   <= r_i[7:0];
      if (w_start) begin
        r_pend <= 1'b0;
      end else if ((r_state == S_COPY) && force_reload) begin
        r_pend <= 1'b1;
      end
      r_overrun <= vblank_start && (r_state != S_IDLE);
    end
  end

  // Resident-frame tracking.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cur_frame <= '0;
      r_cur_valid <= 1'b0;
    end else begin
      if ((r_state != S_COPY) && force_reload) begin
        r_cur_valid <= 1'b0;
      end else if (r_we && (r_waddr == 8'd0)) begin
        // First pixel overwritten: RAM now holds a mix of two frames.
        r_cur_valid <= 1'b0;
      end else if (w_copy_last) begin
        r_cur_valid <= !(r_pend || force_reload);
      end
      if (w_copy_last) begin
        r_cur_frame <= r_sel;
      end
    end
  end

  assign rom_addr  = w_reading ? {r_sel, r_i[7:0]} : '0;
  assign ram_we    = r_we;
  assign ram_waddr = r_waddr;
  assign ram_wdata = rom_data;
  assign busy      = (r_state == S_COPY);
  assign done      = (r_state == S_DONE);
  assign cur_frame = r_cur_frame;
  assign cur_valid = r_cur_valid;
  assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sprite_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_frame_loader
// Description : Self-checking bench for sprite_frame_loader with a timeline
//               model (cycles elapsed since the copy was triggered).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_frame_loader;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic        vblank_start = 1'b0;
  logic        load_en = 1'b0;
  logic [2:0]  frame_sel = '0;
  logic        force_reload = 1'b0;
  logic [10:0] rom_addr;
  logic [5:0]  rom_data = '0;
  logic        ram_we;
  logic [7:0]  ram_waddr;
  logic [5:0]  ram_wdata;
  logic        busy, done, cur_valid, overrun;
  logic [2:0]  cur_frame;

  int n_vec = 0;
  int n_err = 0;
  int wr_cnt = 0, done_cnt = 0, ov_cnt = 0;

  sprite_frame_loader #(.FRAMES(8), .DATA_W(6)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .vblank_start(vblank_start),
    .load_en(load_en), .frame_sel(frame_sel), .force_reload(force_reload),
    .rom_addr(rom_addr), .rom_data(rom_data), .ram_we(ram_we),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .busy(busy), .done(done),
    .cur_frame(cur_frame), .cur_valid(cur_valid), .overrun(overrun)
  );

  always #5 Clk = ~Clk;

  function automatic logic [5:0] romf(input int a);
    int v;
    v = a * 37 + a / 32;
    return v[5:0] ^ 6'h15;
  endfunction

  // Synchronous ROM: data valid one cycle after the address.
  always @(posedge Clk) rom_data <= romf(int'(rom_addr));

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: d = cycles since the triggering edge (0 = not copying).
  int         d = 0;
  logic [2:0] m_sel = '0, m_cur = '0;
  bit         m_valid = 0, m_pend = 0, m_ov = 0;

  always @(posedge Clk) begin
    if (!Reset_n) begin
      d = 0; m_cur = '0; m_valid = 0; m_pend = 0; m_ov = 0;
    end else begin
      m_ov = vblank_start && (d != 0);
      if (d == 0) begin
        if (vblank_start && load_en && (!m_valid || frame_sel != m_cur || force_reload)) begin
          d = 1; m_sel = frame_sel; m_pend = 0;
        end
        if (force_reload) m_valid = 0;
      end else if (d <= 257) begin
        if (force_reload) m_pend = 1;
        if (d == 2) m_valid = 0;
        if (d == 257) begin m_cur = m_sel; m_valid = !m_pend; end
        d++;
      end else begin
        d = 0;
        if (force_reload) m_valid = 0;
      end
    end
  end

  always @(negedge Clk) begin
    if (!Reset_n) begin
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_cur_frame", cur_frame, 0);
      chk("rst_cur_valid", cur_valid, 0);
    end else begin
      chk("rom_addr", rom_addr, (d >= 1 && d <= 256) ? m_sel * 256 + d - 1 : 0);
      chk("ram_we", ram_we, (d >= 2 && d <= 257) ? 1 : 0);
      if (d >= 2 && d <= 257) begin
        chk("ram_waddr", ram_waddr, d - 2);
        chk("ram_wdata", ram_wdata, romf(m_sel * 256 + d - 2));
      end
      chk("busy", busy, (d >= 1 && d <= 257) ? 1 : 0);
      chk("done", done, (d == 258) ? 1 : 0);
      chk("overrun", overrun, m_ov);
      chk("cur_frame", cur_frame, m_cur);
      chk("cur_valid", cur_valid, m_valid);
      if (ram_we) wr_cnt++;
      if (done) done_cnt++;
      if (overrun) ov_cnt++;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_vblank();
    vblank_start = 1'b1;
    tick();
    vblank_start = 1'b0;
  endtask

  int s_wr, s_done;

  initial begin
    #2 Reset_n = 1'b0;
    repeat (3) tick();
    Reset_n = 1'b1;
    tick();

    // Basic copy of frame 3.
    load_en = 1'b1; frame_sel = 3'd3;
    pulse_vblank();
    chk("lit_first_addr", rom_addr, 11'h300);
    repeat (255) tick();
    chk("lit_last_addr", rom_addr, 11'h3FF);
    repeat (5) tick();
    chk("lit_frame3", cur_frame, 3);
    chk("lit_valid1", cur_valid, 1);
    chk("lit_writes256", wr_cnt, 256);
    chk("lit_done1", done_cnt, 1);

    // Same frame again: nothing happens.
    s_wr = wr_cnt; s_done = done_cnt;
    pulse_vblank();
    repeat (10) tick();
    chk("lit_repeat_nowr", wr_cnt, s_wr);
    chk("lit_repeat_nodone", done_cnt, s_done);

    // Overrun mid-copy.
    frame_sel = 3'd5;
    pulse_vblank();
    repeat (99) tick();
    pulse_vblank();
    repeat (170) tick();
    chk("lit_ov1", ov_cnt, 1);
    chk("lit_frame5", cur_frame, 5);
    chk("lit_ov_writes", wr_cnt, s_wr + 256);

    // Reset mid-copy, then a full copy of frame 3.
    frame_sel = 3'd1;
    pulse_vblank();
    repeat (49) tick();
    Reset_n = 1'b0;
    #1;
    chk("lit_rst_we", ram_we, 0);
    chk("lit_rst_busy", busy, 0);
    repeat (2) tick();
    Reset_n = 1'b1;
    tick();
    frame_sel = 3'd3;
    pulse_vblank();
    repeat (262) tick();
    chk("lit_after_rst_frame", cur_frame, 3);
    chk("lit_after_rst_valid", cur_valid, 1);

    // force_reload in IDLE forces a reload of the same frame.
    force_reload = 1'b1; tick(); force_reload = 1'b0; tick();
    chk("lit_force_clr", cur_valid, 0);
    s_wr = wr_cnt;
    pulse_vblank();
    repeat (262) tick();
    chk("lit_force_copy", wr_cnt, s_wr + 256);

    // load_en low ignores vblank; frame_sel/load_en changes mid-copy ignored.
    load_en = 1'b0; frame_sel = 3'd6; s_wr = wr_cnt;
    pulse_vblank();
    repeat (5) tick();
    chk("lit_noload", wr_cnt, s_wr);
    load_en = 1'b1;
    pulse_vblank();
    repeat (29) tick();
    frame_sel = 3'd2; load_en = 1'b0;
    repeat (240) tick();
    load_en = 1'b1;
    chk("lit_frame6", cur_frame, 6);

    // force_reload during copy leaves the frame invalid.
    frame_sel = 3'd4;
    pulse_vblank();
    repeat (100) tick();
    force_reload = 1'b1; tick(); force_reload = 1'b0;
    repeat (170) tick();
    chk("lit_force_copy_valid", cur_valid, 0);
    pulse_vblank();
    repeat (262) tick();
    chk("lit_reload_valid", cur_valid, 1);

    // Simultaneous force_reload and vblank with the resident frame.
    s_done = done_cnt;
    force_reload = 1'b1; vblank_start = 1'b1;
    tick();
    force_reload = 1'b0; vblank_start = 1'b0;
    repeat (262) tick();
    chk("lit_simul_done", done_cnt, s_done + 1);
    chk("lit_simul_valid", cur_valid, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sprite_frame_loader.md
SPRITE_FRAME_LOADER -- requirements
Module: sprite_frame_loader

Interface
REQ-001 SHALL have parameter FRAMES, default 8, the number of 256-pixel animation frames in sprite ROM (power of two, 2..16).
REQ-002 SHALL have parameter DATA_W, default 6, the palette-index width of ROM and sprite RAM pixels.
REQ-003 SHALL have port Clk  input  1  as the single clock; all state updates on rising edge.
REQ-004 SHALL have port Reset_n  input  1  as the reset, asynchronous assert, active-low.
REQ-005 SHALL have port vblank_start  input  1  as a one-cycle pulse at the start of vertical blank.
REQ-006 SHALL have port load_en  input  1  to enable frame loading; when 0, vblank_start is ignored.
REQ-007 SHALL have port frame_sel  input  log2(FRAMES)  as the animation frame requested for next display.
REQ-008 SHALL have port force_reload  input  1  as a pulse that invalidates the resident frame.
REQ-009 SHALL have port rom_addr  output  log2(FRAMES)+8  as the sprite ROM read address.
REQ-010 SHALL have port rom_data  input  DATA_W  as sprite ROM data, valid one cycle after rom_addr.
REQ-011 SHALL have ports ram_we  output  1, ram_waddr  output  8 and ram_wdata  output  DATA_W  driving the sprite RAM write port.
REQ-012 SHALL have port busy  output  1  high while a copy is in progress.
REQ-013 SHALL have port done  output  1  as a one-cycle pulse when a copy completes.
REQ-014 SHALL have port cur_frame  output  log2(FRAMES)  as the frame resident in sprite RAM.
REQ-015 SHALL have port cur_valid  output  1  high when cur_frame reflects the RAM contents.
REQ-016 SHALL have port overrun  output  1  as a one-cycle pulse when a vblank_start is dropped.

Function
REQ-017 SHALL implement states IDLE, COPY and DONE.
REQ-018 In IDLE, vblank_start=1 with load_en=1 and (cur_valid=0 or frame_sel!=cur_frame) at edge T SHALL latch frame_sel into sel_q and enter COPY.
REQ-019 In IDLE, vblank_start with load_en=0, or with cur_valid=1 and frame_sel==cur_frame, SHALL cause no state change and no write.
REQ-020 In COPY, the index counter i SHALL run 0..255 over cycles T+1..T+256 with rom_addr={sel_q,i}; rom_addr SHALL be 0 outside COPY.
REQ-021 The write stage SHALL assert ram_we=1 with ram_waddr=i-1 and ram_wdata=rom_data in cycles T+2..T+257, exactly 256 writes, ascending, none skipped or repeated.
REQ-022 ram_we SHALL be 0 in every other cycle; ram_waddr and ram_wdata are don't-care when ram_we=0.
REQ-023 The state SHALL change to DONE after the write at index 255, so DONE is cycle T+258; DONE SHALL return to IDLE after one cycle.
REQ-024 busy SHALL be 1 in cycles T+1..T+257 and 0 in DONE and IDLE.
REQ-025 In DONE, done SHALL be 1, cur_frame SHALL take sel_q and cur_valid SHALL be set to 1, with the new values visible from T+258.
REQ-026 cur_valid SHALL be cleared on the edge it is written from the cycle following the first ram_we of a copy, because RAM contents become mixed.
REQ-027 A vblank_start arriving in COPY or DONE SHALL be dropped and SHALL pulse overrun in the following cycle; the copy SHALL continue unaffected.
REQ-028 force_reload in IDLE SHALL clear cur_valid next cycle.
REQ-029 force_reload in COPY or DONE SHALL not alter the copy but SHALL leave cur_valid=0 after DONE.
REQ-030 A change of frame_sel or load_en during COPY SHALL have no effect on the running copy.
REQ-031 Simultaneous force_reload and vblank_start in IDLE SHALL start a copy regardless of cur_frame.

Reset
REQ-032 Reset_n=0 SHALL immediately force state=IDLE, i=0, rom_addr=0, ram_we=0, busy=0, done=0, overrun=0, cur_frame=0 and cur_valid=0, including mid-copy.
REQ-033 After reset release, the first qualifying vblank_start SHALL always trigger a copy.

Verification
REQ-034 Reset, then load_en=1, frame_sel=3 and vblank_start at T -> rom_addr 0x300..0x3FF over T+1..T+256; 256 writes with waddr 0..255 and data from ROM at T+2..T+257; done at T+258; cur_frame=3, cur_valid=1.
REQ-035 Repeat vblank_start with frame_sel=3 -> no busy, no writes, no done.
REQ-036 Apply vblank_start at T+100 of a copy -> overrun=1 at T+101; write sequence intact; done still at T+258.
REQ-037 Assert Reset_n=0 at T+50 -> ram_we=0 and busy=0 immediately, cur_valid=0; a new vblank_start with frame_sel=3 performs a full copy.
REQ-038 Pulse force_reload in IDLE, then vblank_start with an unchanged frame_sel -> full copy performed.
REQ-039 Assert load_en=0 with vblank_start -> no activity; frame_sel changed mid-copy -> written data still from sel_q.
